// File: rtl/ecm_output_control_sequencer_if.sv
// Output-control write bus between the sequencer (master) and ecm_output_block (slave).
// Output_control_valid is a one-cycle write strobe with no back-pressure: the slave
// must accept index/control on every cycle valid is high; both are don't-care otherwise.
interface ecm_output_control_sequencer_if #(
  parameter int CHANNEL_INDEX_WIDTH = 4,
  parameter int CONTROL_WIDTH       = 2
);
  logic                           Output_control_valid;
  logic [CHANNEL_INDEX_WIDTH-1:0] Output_control_channel_index;
  logic [CONTROL_WIDTH-1:0]       Output_control_control;

  modport master (
    output Output_control_valid,
    output Output_control_channel_index,
    output Output_control_control
  );

  modport slave (
    input Output_control_valid,
    input Output_control_channel_index,
    input Output_control_control
  );
endinterface

// File: rtl/ecm_output_control_sequencer.sv
// Sequences per-channel control writes into ecm_output_block: programs a snapshot of the
// shadow table on dwell start, reports transmit status, and flushes all channels on dwell end.
module ecm_output_control_sequencer #(
  parameter int NUM_CHANNELS        = 16,
  parameter int CHANNEL_INDEX_WIDTH = 4,
  parameter int CONTROL_WIDTH       = 2,
  parameter int WRITE_GAP           = 0
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Cfg_valid,
  input  logic [CHANNEL_INDEX_WIDTH-1:0] Cfg_channel_index,
  input  logic [CONTROL_WIDTH-1:0]       Cfg_control,
  input  logic                           Dwell_start,
  input  logic                           Dwell_done,
  ecm_output_control_sequencer_if.master oc,
  output logic                           Dwell_active_transmit,
  output logic [CHANNEL_INDEX_WIDTH:0]   Dwell_transmit_count,
  output logic                           Busy,
  output logic                           Error_start_while_busy,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROGRAM = 2'd1,
    ACTIVE  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_CH    = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [2:0]                     GAP_RELOAD = 3'(WRITE_GAP);

  state_t                         state, state_next;
  logic [CONTROL_WIDTH-1:0]       shadow [NUM_CHANNELS];
  logic [CONTROL_WIDTH-1:0]       active [NUM_CHANNELS];
  logic [CHANNEL_INDEX_WIDTH-1:0] ch_idx;
  logic [2:0]                     gap_cnt;
  logic [CHANNEL_INDEX_WIDTH:0]   acc;
  logic                           pending_done;
  logic                           in_pass, write_cycle, step_done, pass_end;

  always_comb begin
    state_next  = state;
    in_pass     = (state == PROGRAM) || (state == FLUSH);
    write_cycle = in_pass && (gap_cnt == 3'd0);
    // A channel slot ends on its write cycle when there is no gap, else on the last gap cycle.
    step_done   = in_pass && (write_cycle ? (WRITE_GAP == 0) : (gap_cnt == 3'd1));
    pass_end    = step_done && (ch_idx == LAST_CH);
    case (state)
      IDLE:    if (Dwell_start) state_next = PROGRAM;
      PROGRAM: if (pass_end) state_next = (pending_done || Dwell_done) ? FLUSH : ACTIVE;
      ACTIVE:  if (Dwell_done) state_next = FLUSH;
      FLUSH:   if (pass_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      ch_idx       <= '0;
      gap_cnt      <= '0;
      acc          <= '0;
      pending_done <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (Cfg_valid) shadow[Cfg_channel_index] <= Cfg_control;

      if (state == IDLE && Dwell_start) begin
        // Snapshot includes a shadow write landing in the same cycle.
        for (int i = 0; i < NUM_CHANNELS; i++)
          active[i] <= (Cfg_valid && Cfg_channel_index == CHANNEL_INDEX_WIDTH'(i)) ?
                       Cfg_control : shadow[i];
        acc          <= '0;
        ch_idx       <= '0;
        gap_cnt      <= '0;
        pending_done <= 1'b0;
      end

      if (in_pass) begin
        if (write_cycle && state == PROGRAM && active[ch_idx] != '0) acc <= acc + 1'b1;
        if (step_done) begin
          gap_cnt <= '0;
          ch_idx  <= pass_end ? '0 : ch_idx + 1'b1;
        end else if (write_cycle) begin
          gap_cnt <= GAP_RELOAD;
        end else begin
          gap_cnt <= gap_cnt - 3'd1;
        end
      end

      if (state == PROGRAM && Dwell_done) pending_done <= 1'b1;
      if (state == FLUSH && pass_end) pending_done <= 1'b0;
    end
  end

  always_comb begin
    oc.Output_control_valid         = write_cycle;
    oc.Output_control_channel_index = write_cycle ? ch_idx : '0;
    oc.Output_control_control       = (write_cycle && state == PROGRAM) ? active[ch_idx] : '0;
    Dwell_active_transmit           = (state == ACTIVE);
    Dwell_transmit_count            = (state == ACTIVE) ? acc : '0;
    Busy                            = (state != IDLE);
    Error_start_while_busy          = Dwell_start && (state != IDLE);
    dbg_state                       = state;
  end

endmodule
